pc_branch_unit: RTL and testbench

- Program-counter and branch-resolution stage sitting directly downstream of the 8-bit accumulator ALU.
- Captures the ALU's z/c/n/v flags into a status register and resolves conditional branches, calls and returns against those registered flags.
- Branch targets come from a small writable target lookup table.
- Drives the instruction-fetch address and feeds the registered carry back to the ALU carry input.

---
 rtl/pc_branch_unit.sv | 175 +++++++++++++++++
 tb/tb_pc_branch_unit.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Program counter and branch-resolution stage: registers the ALU flags, resolves
// conditional branches, calls and returns, and drives the fetch address.
module pc_branch_unit #(
    parameter int PC_W        = 10,
    parameter int LUT_DEPTH   = 16,
    parameter int STACK_DEPTH = 4,
    localparam int IDX_W      = $clog2(LUT_DEPTH),
    localparam int SP_W       = $clog2(STACK_DEPTH + 1),
    localparam int STK_IDX_W  = $clog2(STACK_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_in,
    input  logic             stall,
    input  logic             flag_we,
    input  logic             z_in,
    input  logic             c_in,
    input  logic             n_in,
    input  logic             v_in,
    input  logic             br_en,
    input  logic [2:0]       br_cond,
    input  logic [IDX_W-1:0] br_idx,
    input  logic             call,
    input  logic             ret,
    input  logic             lut_we,
    input  logic [IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]  lut_wdata,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic             taken,
    output logic             z_q,
    output logic             c_q,
    output logic             n_q,
    output logic             v_q,
    output logic             stack_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          state;
    logic [PC_W-1:0] lut   [LUT_DEPTH];
    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0] sp;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] stack_top;
    logic            stack_empty;
    logic            stack_full;
    logic            active;
    logic            cond_true;
    logic            do_ret;
    logic            do_call;
    logic            push_en;

    assign running     = (state == ST_RUN);
    assign done        = (state == ST_DONE);
    assign active      = running && !stall;
    assign pc_inc      = pc + PC_W'(1);
    assign br_target   = lut[br_idx];
    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_top   = stack[STK_IDX_W'(sp - SP_W'(1))];

    // Priority decode: halt beats ret beats call beats branch.
    assign do_ret  = active && !halt_in && ret;
    assign do_call = active && !halt_in && !ret && call;
    assign push_en = do_call && !stack_full;

    // Condition is evaluated against the flags registered before this edge.
    always_comb begin
        // NOTE: default assignment first so no path leaves cond_true unassigned (no latch).
        cond_true = 1'b0;
        case (br_cond)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = z_q;
            3'b010: cond_true = !z_q;
            3'b011: cond_true = n_q;
            3'b100: cond_true = !n_q && !z_q;
            3'b101: cond_true = c_q;
            3'b110: cond_true = !c_q;
            3'b111: cond_true = v_q;
            default: cond_true = 1'b0;
        endcase
    end

    // NOTE: the return-stack storage carries no reset; only sp defines which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack[STK_IDX_W'(sp)] <= pc_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            state     <= ST_IDLE;
            pc        <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            taken     <= 1'b0;
            stack_err <= 1'b0;
            sp        <= '0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    taken <= 1'b0;
                    if (lut_we) begin
                        lut[lut_waddr] <= lut_wdata;
                    end
                    if (start) begin
                        state     <= ST_RUN;
                        pc        <= '0;
                        z_q       <= 1'b0;
                        c_q       <= 1'b0;
                        n_q       <= 1'b0;
                        v_q       <= 1'b0;
                        stack_err <= 1'b0;
                        sp        <= '0;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        taken <= 1'b0;
                        if (flag_we) begin
                            z_q <= z_in;
                            c_q <= c_in;
                            n_q <= n_in;
                            v_q <= v_in;
                        end
                        if (halt_in) begin
                            state <= ST_DONE;
                        end else if (do_ret) begin
                            if (stack_empty) begin
                                stack_err <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                pc    <= stack_top;
                                sp    <= sp - SP_W'(1);
                                taken <= 1'b1;
                            end
                        end else if (do_call) begin
                            if (stack_full) begin
                                stack_err <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                pc    <= br_target;
                                sp    <= sp + SP_W'(1);
                                taken <= 1'b1;
                            end
                        end else if (br_en && cond_true) begin
                            pc    <= br_target;
                            taken <= 1'b1;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Self-checking bench for pc_branch_unit: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_pc_branch_unit;

    localparam int PC_W        = 10;
    localparam int LUT_DEPTH   = 16;
    localparam int STACK_DEPTH = 4;
    localparam int IDX_W       = $clog2(LUT_DEPTH);
    localparam int PC_MOD      = 1 << PC_W;
    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start, halt_in, stall, flag_we;
    logic             z_in, c_in, n_in, v_in;
    logic             br_en, call, ret, lut_we;
    logic [2:0]       br_cond;
    logic [IDX_W-1:0] br_idx, lut_waddr;
    logic [PC_W-1:0]  lut_wdata;
    logic [PC_W-1:0]  pc;
    logic             running, done, taken, z_q, c_q, n_q, v_q, stack_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_state;
    int m_pc;
    bit m_z, m_c, m_n, m_v, m_taken, m_err;
    int m_lut [LUT_DEPTH];
    int m_stack [$];

    pc_branch_unit #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .STACK_DEPTH(STACK_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_in(halt_in), .stall(stall),
        .flag_we(flag_we), .z_in(z_in), .c_in(c_in), .n_in(n_in), .v_in(v_in),
        .br_en(br_en), .br_cond(br_cond), .br_idx(br_idx), .call(call), .ret(ret),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .pc(pc), .running(running), .done(done), .taken(taken),
        .z_q(z_q), .c_q(c_q), .n_q(n_q), .v_q(v_q), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        start = 0; halt_in = 0; stall = 0; flag_we = 0;
        z_in = 0; c_in = 0; n_in = 0; v_in = 0;
        br_en = 0; br_cond = 3'd0; br_idx = '0; call = 0; ret = 0;
        lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_pc = 0; m_taken = 0; m_err = 0;
        m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        foreach (m_lut[i]) m_lut[i] = 0;
        m_stack.delete();
    endtask

    function automatic bit cond_holds(input logic [2:0] sel);
        case (sel)
            3'd0: return 1'b1;
            3'd1: return m_z;
            3'd2: return !m_z;
            3'd3: return m_n;
            3'd4: return !m_n && !m_z;
            3'd5: return m_c;
            3'd6: return !m_c;
            default: return m_v;
        endcase
    endfunction

    // Applies one clock edge's worth of specified behaviour to the model.
    task automatic model_edge();
        bit go;
        if (m_state != M_RUN) begin
            m_taken = 0;
            if (lut_we) m_lut[lut_waddr] = int'(lut_wdata);
            if (start) begin
                m_state = M_RUN; m_pc = 0; m_err = 0;
                m_z = 0; m_c = 0; m_n = 0; m_v = 0;
                m_stack.delete();
            end
        end else if (!stall) begin
            go = cond_holds(br_cond);
            m_taken = 0;
            if (halt_in) begin
                m_state = M_DONE;
            end else if (ret) begin
                if (m_stack.size() == 0) begin
                    m_err = 1; m_state = M_DONE;
                end else begin
                    m_pc = m_stack.pop_back(); m_taken = 1;
                end
            end else if (call) begin
                if (m_stack.size() == STACK_DEPTH) begin
                    m_err = 1; m_state = M_DONE;
                end else begin
                    m_stack.push_back((m_pc + 1) % PC_MOD);
                    m_pc = m_lut[br_idx]; m_taken = 1;
                end
            end else if (br_en && go) begin
                m_pc = m_lut[br_idx]; m_taken = 1;
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
            if (flag_we) begin
                m_z = z_in; m_c = c_in; m_n = n_in; m_v = v_in;
            end
        end
    endtask

    // One clock: model follows the current inputs, DUT sampled 1ns after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        model_reset();
        #3;
        checks++;
        if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0 || taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl pc=%h run=%b done=%b taken=%b required pc=000 run=0 done=0 taken=0",
                     pc, running, done, taken);
        end
        checks++;
        if ({z_q, c_q, n_q, v_q, stack_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b required=00000", {z_q, c_q, n_q, v_q, stack_err});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        step();
        checks++;
        if (pc !== 10'd0 || running !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_hold pc=%h run=%b required pc=000 run=0", pc, running);
        end
    endtask

    task automatic test_sequential();
        clear_inputs(); lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h120; step();
        clear_inputs(); lut_we = 1; lut_waddr = 4'd4; lut_wdata = 10'h010; step();
        clear_inputs(); lut_we = 1; lut_waddr = 4'd5; lut_wdata = 10'h3FD; step();
        clear_inputs(); start = 1; step();
        checks++;
        if (pc !== 10'd0 || running !== 1'b1 || taken !== 1'b0) begin
            failures++;
            $display("FAIL start pc=%h run=%b taken=%b required pc=000 run=1 taken=0", pc, running, taken);
        end
        for (int k = 1; k <= 4; k++) begin
            clear_inputs();
            if (k == 2) begin lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h055; end
            if (k == 3) start = 1;
            step();
            checks++;
            if (pc !== PC_W'(k) || running !== 1'b1 || taken !== 1'b0) begin
                failures++;
                $display("FAIL seq_pc k=%0d pc=%h run=%b taken=%b required pc=%h run=1 taken=0",
                         k, pc, running, taken, PC_W'(k));
            end
        end
    endtask

    task automatic test_flag_branch();
        clear_inputs();
        for (int b = 0; b < 20 && pc !== 10'd5; b++) step();
        checks++;
        if (pc !== 10'd5) begin
            failures++;
            $display("FAIL reach_pc5 pc=%h required=005", pc);
        end
        clear_inputs(); flag_we = 1; z_in = 1; step();
        checks++;
        if (pc !== 10'd6 || z_q !== 1'b1) begin
            failures++;
            $display("FAIL flag_capture pc=%h z_q=%b required pc=006 z_q=1", pc, z_q);
        end
        clear_inputs(); br_en = 1; br_cond = 3'b001; br_idx = 4'd3; step();
        checks++;
        if (pc !== 10'h120 || taken !== 1'b1) begin
            failures++;
            $display("FAIL branch_z_taken pc=%h taken=%b required pc=120 taken=1", pc, taken);
        end
        clear_inputs(); step();
        checks++;
        if (pc !== 10'h121 || taken !== 1'b0) begin
            failures++;
            $display("FAIL taken_pulse pc=%h taken=%b required pc=121 taken=0", pc, taken);
        end
        clear_inputs(); br_en = 1; br_cond = 3'b010; br_idx = 4'd3; step();
        checks++;
        if (pc !== 10'h122 || taken !== 1'b0) begin
            failures++;
            $display("FAIL branch_nz_not_taken pc=%h taken=%b required pc=122 taken=0", pc, taken);
        end
    endtask

    task automatic test_same_cycle();
        clear_inputs(); flag_we = 1; step();
        clear_inputs(); flag_we = 1; z_in = 1; br_en = 1; br_cond = 3'b001; br_idx = 4'd3; step();
        checks++;
        if (pc !== 10'h124 || taken !== 1'b0 || z_q !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_flags pc=%h taken=%b z_q=%b required pc=124 taken=0 z_q=1",
                     pc, taken, z_q);
        end
    endtask

    task automatic test_call_ret();
        clear_inputs(); br_en = 1; br_cond = 3'b000; br_idx = 4'd4; step();
        checks++;
        if (pc !== 10'h010) begin
            failures++;
            $display("FAIL branch_always pc=%h required=010", pc);
        end
        clear_inputs(); call = 1; br_idx = 4'd3; step();
        checks++;
        if (pc !== 10'h120 || taken !== 1'b1) begin
            failures++;
            $display("FAIL call pc=%h taken=%b required pc=120 taken=1", pc, taken);
        end
        clear_inputs(); ret = 1; step();
        checks++;
        if (pc !== 10'h011 || taken !== 1'b1) begin
            failures++;
            $display("FAIL ret pc=%h taken=%b required pc=011 taken=1", pc, taken);
        end
        for (int k = 1; k <= 5; k++) begin
            clear_inputs(); call = 1; br_idx = 4'd3; step();
            checks++;
            if (pc !== 10'h120 || stack_err !== (k == 5) || done !== (k == 5) || running !== (k != 5)) begin
                failures++;
                $display("FAIL nested_call k=%0d pc=%h err=%b done=%b run=%b required pc=120 err=%b done=%b",
                         k, pc, stack_err, done, running, k == 5, k == 5);
            end
        end
        clear_inputs(); step();
        checks++;
        if (stack_err !== 1'b1 || pc !== 10'h120) begin
            failures++;
            $display("FAIL err_sticky err=%b pc=%h required err=1 pc=120", stack_err, pc);
        end
    endtask

    task automatic test_stall_priority();
        clear_inputs(); start = 1; step();
        checks++;
        if (pc !== 10'd0 || running !== 1'b1 || stack_err !== 1'b0 || {z_q, c_q, n_q, v_q} !== 4'b0) begin
            failures++;
            $display("FAIL restart pc=%h run=%b err=%b flags=%b required pc=000 run=1 err=0 flags=0000",
                     pc, running, stack_err, {z_q, c_q, n_q, v_q});
        end
        clear_inputs(); flag_we = 1; z_in = 1; c_in = 1; n_in = 1; v_in = 1; step();
        clear_inputs(); br_en = 1; br_cond = 3'b000; br_idx = 4'd3; step();
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            stall = 1; halt_in = 1; br_en = 1; br_idx = 4'd4; call = 1; start = 1; flag_we = 1;
            step();
            checks++;
            if (pc !== 10'h120 || running !== 1'b1 || taken !== 1'b1 || {z_q, c_q, n_q, v_q} !== 4'b1111) begin
                failures++;
                $display("FAIL stall_freeze k=%0d pc=%h run=%b taken=%b flags=%b required pc=120 run=1 taken=1 flags=1111",
                         k, pc, running, taken, {z_q, c_q, n_q, v_q});
            end
        end
        clear_inputs(); halt_in = 1; br_en = 1; br_idx = 4'd4; step();
        checks++;
        if (done !== 1'b1 || pc !== 10'h120 || taken !== 1'b0) begin
            failures++;
            $display("FAIL halt_priority done=%b pc=%h taken=%b required done=1 pc=120 taken=0", done, pc, taken);
        end
        clear_inputs(); br_en = 1; br_idx = 4'd4; step();
        checks++;
        if (pc !== 10'h120 || done !== 1'b1) begin
            failures++;
            $display("FAIL done_ignores pc=%h done=%b required pc=120 done=1", pc, done);
        end
        clear_inputs(); start = 1; step();
        checks++;
        if (pc !== 10'd0 || running !== 1'b1 || {z_q, c_q, n_q, v_q} !== 4'b0) begin
            failures++;
            $display("FAIL restart_clear pc=%h run=%b flags=%b required pc=000 run=1 flags=0000",
                     pc, running, {z_q, c_q, n_q, v_q});
        end
        clear_inputs(); ret = 1; step();
        checks++;
        if (stack_err !== 1'b1 || done !== 1'b1 || pc !== 10'd0) begin
            failures++;
            $display("FAIL underflow err=%b done=%b pc=%h required err=1 done=1 pc=000", stack_err, done, pc);
        end
    endtask

    task automatic test_wrap();
        clear_inputs(); start = 1; step();
        clear_inputs(); br_en = 1; br_idx = 4'd5; step();
        clear_inputs(); step(); step();
        checks++;
        if (pc !== 10'h3FF) begin
            failures++;
            $display("FAIL reach_max pc=%h required=3ff", pc);
        end
        step();
        checks++;
        if (pc !== 10'h000) begin
            failures++;
            $display("FAIL wrap pc=%h required=000", pc);
        end
        clear_inputs(); br_en = 1; br_idx = 4'd5; step();
        clear_inputs(); step(); step();
        clear_inputs(); call = 1; br_idx = 4'd4; step();
        clear_inputs(); ret = 1; step();
        checks++;
        if (pc !== 10'h000 || taken !== 1'b1) begin
            failures++;
            $display("FAIL call_wrap_ret pc=%h taken=%b required pc=000 taken=1", pc, taken);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_st;
        for (int i = 0; i < 600; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            halt_in   = ($urandom_range(0, 40) == 0);
            stall     = ($urandom_range(0, 7) == 0);
            flag_we   = ($urandom_range(0, 2) == 0);
            z_in      = 1'($urandom); c_in = 1'($urandom);
            n_in      = 1'($urandom); v_in = 1'($urandom);
            br_en     = ($urandom_range(0, 2) == 0);
            br_cond   = 3'($urandom);
            br_idx    = IDX_W'($urandom);
            call      = ($urandom_range(0, 7) == 0);
            ret       = ($urandom_range(0, 7) == 0);
            lut_we    = ($urandom_range(0, 1) == 0);
            lut_waddr = IDX_W'($urandom);
            lut_wdata = PC_W'($urandom);
            step();
            exp_st = {m_state == M_RUN, m_state == M_DONE, m_taken, m_z, m_c, m_n, m_v, m_err};
            checks++;
            if (pc !== PC_W'(m_pc)) begin
                failures++;
                $display("FAIL rand_pc cyc=%0d pc=%h required=%h", i, pc, PC_W'(m_pc));
            end
            checks++;
            if ({running, done, taken, z_q, c_q, n_q, v_q, stack_err} !== exp_st) begin
                failures++;
                $display("FAIL rand_status cyc=%0d got=%b required=%b (run,done,taken,z,c,n,v,err)",
                         i, {running, done, taken, z_q, c_q, n_q, v_q, stack_err}, exp_st);
            end
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        if (m_state != M_RUN) begin start = 1; step(); clear_inputs(); end
        step(); step();
        @(negedge clk);
        rst_n = 0;
        #1;
        checks++;
        if (pc !== 10'd0 || running !== 1'b0 || done !== 1'b0 || stack_err !== 1'b0 || taken !== 1'b0) begin
            failures++;
            $display("FAIL async_reset pc=%h run=%b done=%b err=%b taken=%b required all zero",
                     pc, running, done, stack_err, taken);
        end
        model_reset();
        #2;
        rst_n = 1;
        clear_inputs(); start = 1; step();
        clear_inputs(); br_en = 1; br_idx = 4'd3; step();
        checks++;
        if (pc !== 10'd0 || taken !== 1'b1) begin
            failures++;
            $display("FAIL lut_cleared pc=%h taken=%b required pc=000 taken=1", pc, taken);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_flag_branch();
        test_same_cycle();
        test_call_ret();
        test_stall_priority();
        test_wrap();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
